// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong reorder buffer for a radix-2 DIF FFT output stream.
// Samples arrive in bit-reversed frame order. Each one is stored at the bit-reversed
// address of its arrival count. A completed bank is then read out in natural order.
// Two banks let one frame be written while the previous frame is read.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o    input handshake; in_sop_i marks the first sample of a frame
//   in_re_i, in_im_i         input sample (bit-reversed order)
//   out_valid_o/out_ready_i  output handshake
//   out_re_o, out_im_o       output sample (natural order), zero when !out_valid_o
//   out_sop_o, out_eop_o     first / last sample of the output frame
//   sop_err_o                one-cycle pulse when in_sop_i resyncs a partial frame
module fft_reorder_buf #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DW    = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_sop_i,
    input  logic [DW-1:0] in_re_i,
    input  logic [DW-1:0] in_im_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_re_o,
    output logic [DW-1:0] out_im_o,
    output logic          out_sop_o,
    output logic          out_eop_o,
    output logic          sop_err_o
);

    localparam int unsigned N = 1 << WIDTH;

    typedef logic [WIDTH-1:0] addr_t;

    function automatic addr_t bitrev(input addr_t a);
        addr_t r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = a[int'(WIDTH) - 1 - i];
        end
        return r;
    endfunction

    // Sample storage: contents are deliberately not reset.
    logic [2*DW-1:0] mem_q [2][N];

    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;
    addr_t      wcnt_q, wcnt_d;
    addr_t      rcnt_q, rcnt_d;
    logic [1:0] full_q, full_d;
    logic       sop_err_q, sop_err_d;

    logic    wr_en, rd_en, resync, wr_last, rd_last;
    addr_t   wr_addr;
    logic [2*DW-1:0] rd_word;

    assign in_ready_o  = ~full_q[wbank_q];
    assign out_valid_o = full_q[rbank_q];

    always_comb begin
        wr_en   = in_valid_i & in_ready_o;
        rd_en   = out_valid_o & out_ready_i;
        // A start-of-frame in the middle of a frame drops the partial frame and
        // restarts at count 0; this sample becomes arrival 0.
        resync  = wr_en & in_sop_i & (wcnt_q != '0);
        wr_addr = resync ? '0 : bitrev(wcnt_q);
        wr_last = wr_en & ~resync & (wcnt_q == '1);
        rd_last = rd_en & (rcnt_q == '1);

        wcnt_d = wcnt_q;
        if (wr_en) begin
            wcnt_d = resync ? addr_t'(1) : wcnt_q + 1'b1;
        end
        rcnt_d    = rd_en ? rcnt_q + 1'b1 : rcnt_q;
        wbank_d   = wbank_q ^ wr_last;
        rbank_d   = rbank_q ^ rd_last;
        sop_err_d = resync;

        // Completion of a write and of a read always refer to different banks.
        full_d = full_q;
        if (rd_last) full_d[rbank_q] = 1'b0;
        if (wr_last) full_d[wbank_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            full_q    <= 2'b00;
            sop_err_q <= 1'b0;
        end else begin
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            full_q    <= full_d;
            sop_err_q <= sop_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wbank_q][wr_addr] <= {in_re_i, in_im_i};
        end
    end

    always_comb begin
        rd_word   = mem_q[rbank_q][rcnt_q];
        out_re_o  = out_valid_o ? rd_word[2*DW-1:DW] : '0;
        out_im_o  = out_valid_o ? rd_word[DW-1:0] : '0;
        out_sop_o = out_valid_o & (rcnt_q == '0);
        out_eop_o = out_valid_o & (rcnt_q == '1);
        sop_err_o = sop_err_q;
    end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Testbench for fft_reorder_buf: random and directed stimulus checked every cycle
// against a frame-level reference model (frames collected by arrival count, emitted
// in natural order as frame[bitrev(k)]).
module tb_fft_reorder_buf;

    localparam int W  = 3;
    localparam int N  = 1 << W;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic          in_sop_i = 1'b0;
    logic [DW-1:0] in_re_i = '0;
    logic [DW-1:0] in_im_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] out_re_o;
    logic [DW-1:0] out_im_o;
    logic          out_sop_o;
    logic          out_eop_o;
    logic          sop_err_o;

    fft_reorder_buf #(
        .WIDTH(W),
        .DW   (DW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_sop_i   (in_sop_i),
        .in_re_i    (in_re_i),
        .in_im_i    (in_im_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_re_o   (out_re_o),
        .out_im_o   (out_im_o),
        .out_sop_o  (out_sop_o),
        .out_eop_o  (out_eop_o),
        .sop_err_o  (sop_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [DW-1:0] q_re[$];
    logic [DW-1:0] q_im[$];
    int            m_pend;
    int            m_rd_idx;
    int            m_wcnt;
    logic [DW-1:0] wb_re[N];
    logic [DW-1:0] wb_im[N];
    logic          m_sop_err;

    // Stimulus queue.
    logic [DW-1:0] s_re[$];
    logic [DW-1:0] s_im[$];
    logic          s_sop[$];
    int            valid_pct;
    int            ready_pct;
    int            sop_err_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bitrev(input int a);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            if (((a >> i) & 1) != 0) r |= 1 << (W - 1 - i);
        end
        return r;
    endfunction

    task automatic model_reset();
        q_re.delete();
        q_im.delete();
        m_pend    = 0;
        m_rd_idx  = 0;
        m_wcnt    = 0;
        m_sop_err = 1'b0;
    endtask

    task automatic push_frame(input bit directed);
        for (int c = 0; c < N; c++) begin
            logic [DW-1:0] re;
            re = directed ? DW'(bitrev(c)) : DW'($urandom);
            s_re.push_back(re);
            s_im.push_back(directed ? -re : DW'($urandom));
            s_sop.push_back(c == 0);
        end
    endtask

    task automatic model_write(input logic [DW-1:0] re, input logic [DW-1:0] im,
                               input logic sop);
        if (sop && m_wcnt != 0) begin
            m_sop_err = 1'b1;
            m_wcnt    = 0;
        end
        wb_re[m_wcnt] = re;
        wb_im[m_wcnt] = im;
        m_wcnt++;
        if (m_wcnt == N) begin
            for (int k = 0; k < N; k++) begin
                q_re.push_back(wb_re[bitrev(k)]);
                q_im.push_back(wb_im[bitrev(k)]);
            end
            m_pend++;
            m_wcnt = 0;
        end
    endtask

    // One clock cycle: drive, check at negedge, update the model at posedge.
    task automatic cycle();
        logic acc, xfer;
        logic [DW-1:0] cur_re, cur_im;
        logic cur_sop;
        cur_re  = '0;
        cur_im  = '0;
        cur_sop = 1'b0;
        if (s_re.size() > 0) begin
            cur_re  = s_re[0];
            cur_im  = s_im[0];
            cur_sop = s_sop[0];
        end
        in_valid_i  = (s_re.size() > 0) && ($urandom_range(99) < valid_pct);
        in_re_i     = cur_re;
        in_im_i     = cur_im;
        in_sop_i    = cur_sop;
        out_ready_i = ($urandom_range(99) < ready_pct);

        @(negedge clk_i);
        check_eq("in_ready", 32'(in_ready_o), 32'(m_pend < 2));
        check_eq("out_valid", 32'(out_valid_o), 32'(m_pend > 0));
        if (m_pend > 0) begin
            check_eq("out_re", 32'(out_re_o), 32'(q_re[0]));
            check_eq("out_im", 32'(out_im_o), 32'(q_im[0]));
            check_eq("out_sop", 32'(out_sop_o), 32'(m_rd_idx == 0));
            check_eq("out_eop", 32'(out_eop_o), 32'(m_rd_idx == N - 1));
        end else begin
            check_eq("out_re_idle", 32'(out_re_o), 32'd0);
            check_eq("out_flags_idle", {30'd0, out_sop_o, out_eop_o}, 32'd0);
        end
        check_eq("sop_err", 32'(sop_err_o), 32'(m_sop_err));
        if (sop_err_o) sop_err_seen++;
        acc  = in_valid_i && (m_pend < 2);
        xfer = (m_pend > 0) && out_ready_i;

        @(posedge clk_i);
        m_sop_err = 1'b0;
        if (xfer) begin
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            m_rd_idx++;
            if (m_rd_idx == N) begin
                m_rd_idx = 0;
                m_pend--;
            end
        end
        if (acc) begin
            model_write(cur_re, cur_im, cur_sop);
            void'(s_re.pop_front());
            void'(s_im.pop_front());
            void'(s_sop.pop_front());
        end
        #1;
    endtask

    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (s_re.size() == 0 && m_pend == 0) break;
            cycle();
        end
        check_eq("drain_left", 32'(s_re.size() + m_pend), 32'd0);
        in_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check_eq({tag, "_out_data"}, {out_re_o, out_im_o}, 32'd0);
        check_eq({tag, "_flags"}, {29'd0, out_sop_o, out_eop_o, sop_err_o}, 32'd0);
    endtask

    initial begin
        int accepted;
        model_reset();
        sop_err_seen = 0;

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic reorder: 0,4,2,6,1,5,3,7 in, 0..7 out.
        valid_pct = 100;
        ready_pct = 100;
        push_frame(1'b1);
        run_until_idle(60);

        // Streaming: 4 back-to-back frames.
        for (int f = 0; f < 4; f++) push_frame(1'b0);
        run_until_idle(120);

        // Backpressure: 3 frames offered with out_ready low.
        for (int f = 0; f < 3; f++) push_frame(1'b0);
        ready_pct = 0;
        repeat (30) cycle();
        accepted = 3 * N - s_re.size();
        check_eq("bp_accepted", 32'(accepted), 32'(2 * N));
        ready_pct = 100;
        run_until_idle(120);

        // Random stalls on both sides.
        valid_pct = 70;
        ready_pct = 50;
        for (int f = 0; f < 6; f++) push_frame(1'b0);
        run_until_idle(600);

        // Resync: 3-sample partial frame then a full frame.
        valid_pct    = 100;
        ready_pct    = 100;
        sop_err_seen = 0;
        for (int c = 0; c < 3; c++) begin
            s_re.push_back(DW'($urandom));
            s_im.push_back(DW'($urandom));
            s_sop.push_back(c == 0);
        end
        push_frame(1'b1);
        run_until_idle(80);
        check_eq("resync_pulses", 32'(sop_err_seen), 32'd1);

        // Reset while output index 3 is presented.
        push_frame(1'b0);
        push_frame(1'b0);
        for (int i = 0; i < 100; i++) begin
            if (m_pend > 0 && m_rd_idx == 3) break;
            cycle();
        end
        check_eq("reached_idx3", 32'(m_rd_idx), 32'd3);
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        s_re.delete();
        s_im.delete();
        s_sop.delete();
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        push_frame(1'b1);
        run_until_idle(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
